// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequences a shared clock-gate enable for NumReq requesters with wake/drain hysteresis.
// Define CLK_GATE_CTRL_STATS_EN to count DRAIN->OFF gating events on gate_cnt_o (tied to 0 otherwise).
module clk_gate_ctrl #(
  parameter int NumReq     = 4,
  parameter int HystCycles = 8,
  parameter int WakeCycles = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] ack_o,
  input  logic              idle_i,
  input  logic              force_on_i,
  output logic              clk_en_o,
  output logic [1:0]        state_o,
  output logic [15:0]       gate_cnt_o
);
  localparam int MaxCycles = HystCycles > WakeCycles ? HystCycles : WakeCycles;
  localparam int CW = $clog2(MaxCycles + 1);
  typedef enum logic [1:0] {Off = 2'd0, Wake = 2'd1, On = 2'd2, Drain = 2'd3} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NumReq-1:0] ack_q, ack_d;
  logic              any_req;
  assign any_req = |req_i | force_on_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      On: begin
        if (!any_req) begin
          state_d = Drain;
          cnt_d   = CW'(HystCycles - 1);
        end
      end
      Drain: begin
        if (any_req) state_d = On;
        else if (!idle_i) cnt_d = CW'(HystCycles - 1);
        else if (cnt_q == '0) state_d = Off;
        else cnt_d = cnt_q - 1'b1;
      end
      Off: begin
        if (any_req) begin
          state_d = Wake;
          cnt_d   = CW'(WakeCycles - 1);
        end
      end
      Wake: begin
        if (cnt_q == '0) state_d = On;
        else cnt_d = cnt_q - 1'b1;
      end
    endcase
  end
  assign ack_d = req_i & {NumReq{state_q == On}};
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= On;
      cnt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end
`ifdef CLK_GATE_CTRL_STATS_EN
  logic [15:0] gate_cnt_q, gate_cnt_d;
  assign gate_cnt_d = (state_q == Drain && state_d == Off && gate_cnt_q != 16'hFFFF) ?
                      gate_cnt_q + 16'd1 : gate_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) gate_cnt_q <= '0;
    else gate_cnt_q <= gate_cnt_d;
  end
  assign gate_cnt_o = gate_cnt_q;
`else
  assign gate_cnt_o = '0;
`endif
  assign clk_en_o = state_q != Off;
  assign state_o  = state_q;
  assign ack_o    = ack_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed scoreboard bench for clk_gate_ctrl (NumReq=4, HystCycles=8, WakeCycles=2).
module tb_clk_gate_ctrl;
`ifdef CLK_GATE_CTRL_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif
  localparam logic [1:0] S_OFF = 2'd0, S_WAKE = 2'd1, S_ON = 2'd2, S_DRAIN = 2'd3;
  typedef struct {
    logic        en;
    logic [1:0]  st;
    logic [3:0]  ack;
    logic [15:0] gc;
    string       name;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic        idle = 1'b1;
  logic        force_on = 1'b0;
  logic [3:0]  ack;
  logic        clk_en;
  logic [1:0]  state;
  logic [15:0] gate_cnt;
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_gc = '0;
  clk_gate_ctrl #(.NumReq(4), .HystCycles(8), .WakeCycles(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ack_o(ack), .idle_i(idle),
    .force_on_i(force_on), .clk_en_o(clk_en), .state_o(state), .gate_cnt_o(gate_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end
  // Monitor: one expected record is due at each negedge after it was queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_chk++;
        if (clk_en !== e.en || state !== e.st || ack !== e.ack || gate_cnt !== e.gc) begin
          n_fail++;
          $display("FAIL %s: got en=%b st=%0d ack=%b gc=%0d, required en=%b st=%0d ack=%b gc=%0d",
                   e.name, clk_en, state, ack, gate_cnt, e.en, e.st, e.ack, e.gc);
        end
      end
    end
  end
  task automatic expect_now(input logic en, input logic [1:0] st, input logic [3:0] a, input string nm);
    exp_t e;
    e.en = en; e.st = st; e.ack = a; e.gc = exp_gc; e.name = nm;
    sb.push_back(e);
  endtask
  // Called at negedge+1: drive inputs, queue the state expected after the next posedge.
  task automatic step(input logic [3:0] r, input logic id, input logic f,
                      input logic en, input logic [1:0] st, input logic [3:0] a, input string nm);
    req = r; idle = id; force_on = f;
    expect_now(en, st, a, nm);
    @(negedge clk);
    #1;
  endtask
  task automatic gated(input string nm);
    if (Stats) exp_gc++;
    step(4'b0000, 1'b1, 1'b0, 1'b0, S_OFF, 4'b0000, nm);
  endtask
  initial begin
    expect_now(1'b1, S_ON, 4'b0000, "reset_state");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    // Gating straight out of reset: DRAIN for 8 edges, OFF on the 9th.
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "boot_drain");
    gated("boot_off");
    step(4'b0000, 1'b1, 1'b0, 1'b0, S_OFF, 4'b0000, "off_hold");
    // Wake from OFF: WAKE, WAKE, ON, then ack.
    step(4'b0010, 1'b1, 1'b0, 1'b1, S_WAKE, 4'b0000, "wake1");
    step(4'b0010, 1'b1, 1'b0, 1'b1, S_WAKE, 4'b0000, "wake2");
    step(4'b0010, 1'b1, 1'b0, 1'b1, S_ON, 4'b0000, "wake_on");
    step(4'b0010, 1'b1, 1'b0, 1'b1, S_ON, 4'b0010, "wake_ack");
    step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "ack_drop");
    // Idle glitch at count 3 reloads the hysteresis counter.
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "pre_glitch");
    step(4'b0000, 1'b0, 1'b0, 1'b1, S_DRAIN, 4'b0000, "idle_glitch");
    for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "post_glitch");
    gated("glitch_off");
    // Request arriving in the same cycle OFF is entered, then request at count 0 of DRAIN.
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_WAKE, 4'b0000, "r0_wake1");
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_WAKE, 4'b0000, "r0_wake2");
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_ON, 4'b0000, "r0_on");
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_ON, 4'b0001, "r0_ack");
    step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "r0_drop");
    for (int i = 0; i < 7; i++) step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "to_cnt0");
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_ON, 4'b0000, "cnt0_req_wins");
    step(4'b0001, 1'b1, 1'b0, 1'b1, S_ON, 4'b0001, "cnt0_ack");
    step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "cnt0_drop");
    // Force-on holds the clock without producing acks.
    for (int i = 0; i < 100; i++) step(4'b0000, 1'b1, 1'b1, 1'b1, S_ON, 4'b0000, "force_on");
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "force_drain");
    gated("force_off");
    // Asynchronous reset while OFF takes effect before the next clock edge.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_gc = '0;
    expect_now(1'b1, S_ON, 4'b0000, "async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    // Multiple requesters directly from ON.
    step(4'b1010, 1'b1, 1'b0, 1'b1, S_ON, 4'b1010, "multi_ack");
    step(4'b1000, 1'b1, 1'b0, 1'b1, S_ON, 4'b1000, "partial_drop");
    step(4'b0000, 1'b1, 1'b0, 1'b1, S_DRAIN, 4'b0000, "all_drop");
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
